// File: rtl/cp0_pkg.sv
// Shared CP0 exception-control constants: ExcCodes, FSM encoding, entry vector.
package cp0_pkg;

  localparam int unsigned EXCCODE_W = 5;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned HW_INT_W  = 6;
  localparam int unsigned XLEN      = 32;

  // Cause.ExcCode values
  localparam logic [EXCCODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCCODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXCCODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXCCODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXCCODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXCCODE_W-1:0] EXC_OV   = 5'd12;

  // Exception-sequencer state encoding
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_CANCEL   = 2'd1;
  localparam logic [STATE_W-1:0] ST_REDIRECT = 2'd2;

  // Default exception/interrupt entry address
  localparam logic [XLEN-1:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines.
module int_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: accepts WB-stage events, updates CP0,
// flushes the pipeline and redirects fetch to the handler or EPC.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] dm_addr,
  input  logic        fetch_error,
  input  logic        inst_reserved,
  input  logic        overflow,
  input  logic        syscall,
  input  logic        brk,
  input  logic        raddr_error,
  input  logic        waddr_error,
  input  logic        eret,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [31:0] epc,
  input  logic [5:0]  hw_int,
  input  logic        timer_int,
  input  logic        redirect_ready,
  output logic        exc_wen,
  output logic        exl_clr,
  output logic [4:0]  exccode,
  output logic [31:0] epc_wdata,
  output logic        badvaddr_wen,
  output logic [31:0] badvaddr_wdata,
  output logic [5:0]  cause_ip_hw,
  output logic        commit_block,
  output logic        cancel,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic [HW_INT_W-1:0]  ip_hw;
  logic [7:0]           ip_vec;
  logic                 int_pend;
  logic                 exc_any;
  logic                 accept;
  logic [EXCCODE_W-1:0] code_sel;

  int_sync #(
    .WIDTH(HW_INT_W)
  ) u_int_sync (
    .clk   (clk),
    .resetn(resetn),
    .d_i   (hw_int),
    .q_o   (ip_hw)
  );

  assign cause_ip_hw = ip_hw;
  assign redirect_pc = redirect_pc_q;

  // Timer shares IP7 with hw line 5
  assign ip_vec   = {ip_hw[5] | timer_int, ip_hw[4:0], cause_ip_sw};
  assign int_pend = status_ie & ~status_exl & (|(status_im & ip_vec));
  assign exc_any  = int_pend | fetch_error | inst_reserved | overflow | syscall
                  | brk | raddr_error | waddr_error;
  // Gated by resetn so nothing is issued while reset is asserted
  assign accept   = resetn & (state_q == ST_IDLE) & wb_valid & (exc_any | eret);

  // ExcCode priority encoder
  always_comb begin
    code_sel = EXC_INT;
    if (int_pend)           code_sel = EXC_INT;
    else if (fetch_error)   code_sel = EXC_ADEL;
    else if (inst_reserved) code_sel = EXC_RI;
    else if (overflow)      code_sel = EXC_OV;
    else if (syscall)       code_sel = EXC_SYS;
    else if (brk)           code_sel = EXC_BP;
    else if (raddr_error)   code_sel = EXC_ADEL;
    else if (waddr_error)   code_sel = EXC_ADES;
  end

  // Next state, redirect target latch and CP0/pipeline strobes
  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    exc_wen        = 1'b0;
    exl_clr        = 1'b0;
    exccode        = '0;
    epc_wdata      = '0;
    badvaddr_wen   = 1'b0;
    badvaddr_wdata = '0;
    commit_block   = 1'b0;
    cancel         = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_CANCEL;
          commit_block = 1'b1;
          if (exc_any) begin
            exc_wen       = 1'b1;
            exccode       = code_sel;
            epc_wdata     = wb_pc;
            redirect_pc_d = EXC_VEC;
            // BadVAddr follows the faulting address source, fetch taking precedence
            if (fetch_error) begin
              badvaddr_wen   = 1'b1;
              badvaddr_wdata = wb_pc;
            end else if (raddr_error | waddr_error) begin
              badvaddr_wen   = 1'b1;
              badvaddr_wdata = dm_addr;
            end
          end else begin
            exl_clr       = 1'b1;
            redirect_pc_d = epc;
          end
        end
      end
      ST_CANCEL: begin
        cancel       = 1'b1;
        commit_block = 1'b1;
        state_d      = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        commit_block   = 1'b1;
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and redirect target registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc, dm_addr, epc;
  logic        fetch_error, inst_reserved, overflow, syscall, brk;
  logic        raddr_error, waddr_error, eret;
  logic        status_ie, status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  hw_int;
  logic        timer_int, redirect_ready;
  logic        exc_wen, exl_clr, badvaddr_wen, commit_block, cancel, redirect_valid;
  logic [4:0]  exccode;
  logic [31:0] epc_wdata, badvaddr_wdata, redirect_pc;
  logic [5:0]  cause_ip_hw;

  cp0_exc_ctrl #(.EXC_VEC(VEC)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .dm_addr(dm_addr),
    .fetch_error(fetch_error), .inst_reserved(inst_reserved), .overflow(overflow),
    .syscall(syscall), .brk(brk), .raddr_error(raddr_error), .waddr_error(waddr_error),
    .eret(eret), .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .cause_ip_sw(cause_ip_sw), .epc(epc), .hw_int(hw_int), .timer_int(timer_int),
    .redirect_ready(redirect_ready), .exc_wen(exc_wen), .exl_clr(exl_clr),
    .exccode(exccode), .epc_wdata(epc_wdata), .badvaddr_wen(badvaddr_wen),
    .badvaddr_wdata(badvaddr_wdata), .cause_ip_hw(cause_ip_hw),
    .commit_block(commit_block), .cancel(cancel), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pos = -1 idle, 0 = flush cycle, >=1 = cycles spent offering redirect
  int          pos;
  logic [31:0] m_rpc;
  logic [5:0]  m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    resetn = 1'b1; wb_valid = 1'b0; wb_pc = '0; dm_addr = '0; epc = '0;
    fetch_error = 1'b0; inst_reserved = 1'b0; overflow = 1'b0; syscall = 1'b0;
    brk = 1'b0; raddr_error = 1'b0; waddr_error = 1'b0; eret = 1'b0;
    status_ie = 1'b0; status_exl = 1'b0; status_im = '0; cause_ip_sw = '0;
    hw_int = '0; timer_int = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    resetn        = ($urandom_range(0, 49) != 0);
    wb_valid      = ($urandom_range(0, 3) != 0);
    wb_pc         = $urandom;
    dm_addr       = $urandom;
    epc           = $urandom;
    fetch_error   = ($urandom_range(0, 15) == 0);
    inst_reserved = ($urandom_range(0, 15) == 0);
    overflow      = ($urandom_range(0, 15) == 0);
    syscall       = ($urandom_range(0, 15) == 0);
    brk           = ($urandom_range(0, 15) == 0);
    raddr_error   = ($urandom_range(0, 15) == 0);
    waddr_error   = ($urandom_range(0, 15) == 0);
    eret          = ($urandom_range(0, 7) == 0);
    status_ie     = 1'($urandom_range(0, 1));
    status_exl    = ($urandom_range(0, 3) == 0);
    status_im     = 8'($urandom);
    cause_ip_sw   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
    hw_int        = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
    timer_int     = ($urandom_range(0, 15) == 0);
    redirect_ready = 1'($urandom_range(0, 1));
  endtask

  // Compare every output against the model, then advance model over one clock
  task automatic tick();
    logic [7:0] ipv;
    logic       ip, excv, acc, bv;
    logic [4:0] code;
    logic       flags [8];
    int         codes [8];
    #1;
    ipv   = {m_s2[5] | timer_int, m_s2[4:0], cause_ip_sw};
    ip    = status_ie && !status_exl && ((status_im & ipv) != 8'd0);
    flags = '{ip, fetch_error, inst_reserved, overflow, syscall, brk, raddr_error, waddr_error};
    codes = '{0, 4, 10, 12, 8, 9, 4, 5};
    excv  = 1'b0;
    code  = 5'd0;
    for (int i = 7; i >= 0; i--) begin
      if (flags[i]) begin
        excv = 1'b1;
        code = 5'(codes[i]);
      end
    end
    acc = resetn && (pos < 0) && wb_valid && (excv || eret);
    bv  = acc && excv && (fetch_error || raddr_error || waddr_error);

    chk("exc_wen",        32'(exc_wen),        32'(acc && excv));
    chk("exl_clr",        32'(exl_clr),        32'(acc && !excv));
    chk("exccode",        32'(exccode),        (acc && excv) ? 32'(code) : 32'd0);
    chk("epc_wdata",      epc_wdata,           (acc && excv) ? wb_pc : 32'd0);
    chk("badvaddr_wen",   32'(badvaddr_wen),   32'(bv));
    chk("badvaddr_wdata", badvaddr_wdata,      !bv ? 32'd0 : (fetch_error ? wb_pc : dm_addr));
    chk("cause_ip_hw",    32'(cause_ip_hw),    32'(m_s2));
    chk("commit_block",   32'(commit_block),   32'(acc || (pos >= 0)));
    chk("cancel",         32'(cancel),         32'(pos == 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(pos >= 1));
    chk("redirect_pc",    redirect_pc,         m_rpc);

    @(posedge clk);
    if (!resetn) begin
      pos = -1; m_rpc = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = hw_int;
      if (acc) begin
        pos   = 0;
        m_rpc = excv ? VEC : epc;
      end else if (pos == 0) begin
        pos = 1;
      end else if (pos > 0) begin
        pos = redirect_ready ? -1 : pos + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pos = -1; m_rpc = '0; m_s1 = '0; m_s2 = '0;
    tick();
    #1;
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_cancel", 32'(cancel), 32'd0);

    // Syscall entry, then a second syscall ignored while busy, then reset mid-redirect
    clear_inputs();
    wb_valid = 1'b1; syscall = 1'b1; wb_pc = 32'hBFC0_0100;
    #1;
    chk("sys_wen", 32'(exc_wen), 32'd1);
    chk("sys_code", 32'(exccode), 32'd8);
    chk("sys_epc", epc_wdata, 32'hBFC0_0100);
    tick();
    #1;
    chk("sys_cancel", 32'(cancel), 32'd1);
    chk("busy_wen_c", 32'(exc_wen), 32'd0);
    tick();
    #1;
    chk("sys_rvalid", 32'(redirect_valid), 32'd1);
    chk("sys_rpc", redirect_pc, VEC);
    chk("busy_wen_r", 32'(exc_wen), 32'd0);
    tick();
    resetn = 1'b0;
    tick();
    clear_inputs();
    #1;
    chk("rst_mid_rvalid", 32'(redirect_valid), 32'd0);
    chk("rst_mid_rpc", redirect_pc, 32'd0);
    chk("rst_mid_commit", 32'(commit_block), 32'd0);
    tick();

    // Fetch error outranks overflow
    wb_valid = 1'b1; fetch_error = 1'b1; overflow = 1'b1; wb_pc = 32'hBFC0_0203;
    #1;
    chk("ferr_code", 32'(exccode), 32'd4);
    chk("ferr_bvaddr", badvaddr_wdata, 32'hBFC0_0203);
    chk("ferr_bvwen", 32'(badvaddr_wen), 32'd1);
    tick();
    clear_inputs();
    redirect_ready = 1'b1;
    tick();
    tick();

    // Eret with fetch stalling the redirect for three cycles
    wb_valid = 1'b1; eret = 1'b1; epc = 32'hBFC0_0040;
    #1;
    chk("eret_exl_clr", 32'(exl_clr), 32'd1);
    chk("eret_no_wen", 32'(exc_wen), 32'd0);
    tick();
    clear_inputs();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("eret_rvalid", 32'(redirect_valid), 32'd1);
      chk("eret_rpc", redirect_pc, 32'hBFC0_0040);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    #1;
    chk("eret_idle", 32'(redirect_valid), 32'd0);
    tick();

    // Hardware interrupt through the synchronizer
    hw_int = 6'b000100; status_im = 8'h10; status_ie = 1'b1;
    tick();
    tick();
    #1;
    chk("hwint_sync", 32'(cause_ip_hw[2]), 32'd1);
    wb_valid = 1'b1; wb_pc = 32'h8000_1234;
    #1;
    chk("hwint_code", 32'(exccode), 32'd0);
    chk("hwint_wen", 32'(exc_wen), 32'd1);
    chk("hwint_commit", 32'(commit_block), 32'd1);
    tick();
    clear_inputs();
    redirect_ready = 1'b1;
    repeat (3) tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_VEC, default 32'hBFC00380, meaning the exception/interrupt entry address.
REQ-002 The block SHALL have ports `clk` (in, 1, clock) and `resetn` (in, 1, reset; synchronous, active-low).
REQ-003 The block SHALL have these WB-stage inputs:
- `wb_valid` (1): WB instruction valid.
- `wb_pc` (32): WB instruction PC.
- `dm_addr` (32): data access address.
REQ-004 The block SHALL have these exception inputs, 1 bit each: `fetch_error`, `inst_reserved`, `overflow`, `syscall`, `brk`, `raddr_error`, `waddr_error`, `eret`.
REQ-005 The block SHALL have these CP0 state inputs:
- `status_ie` (1), `status_exl` (1).
- `status_im` (8): interrupt mask.
- `cause_ip_sw` (2): software interrupt bits.
- `epc` (32): current EPC.
REQ-006 The block SHALL have interrupt inputs `hw_int` (6, asynchronous) and `timer_int` (1, synchronous).
REQ-007 The block SHALL have these CP0 update outputs:
- `exc_wen` (1): pulse that writes EPC, Cause.ExcCode and sets EXL.
- `exl_clr` (1).
- `exccode` (5).
- `epc_wdata` (32).
- `badvaddr_wen` (1), `badvaddr_wdata` (32).
- `cause_ip_hw` (6): synchronized interrupt bits.
REQ-008 The block SHALL have these pipeline control outputs:
- `commit_block` (1): suppresses regfile/HI/LO writes.
- `cancel` (1): flushes all stages.
- `redirect_valid` (1), `redirect_pc` (32).
REQ-009 The block SHALL have input `redirect_ready` (1), the fetch-stage acceptance of a redirect.

Function
REQ-010 The block SHALL implement FSM states IDLE, CANCEL, REDIRECT.
REQ-011 `int_pend` SHALL equal status_ie & ~status_exl & |({cause_ip_hw, timer_int|cause_ip_hw[5]... }) — concretely, int_pend SHALL be status_ie & ~status_exl & |(status_im & {cause_ip_hw[5]|timer_int, cause_ip_hw[4:0], cause_ip_sw}).
REQ-012 An event SHALL be accepted only when in IDLE with wb_valid=1.
REQ-013 Accepted events SHALL be prioritised as: interrupt(0) > fetch_error(4) > inst_reserved(10) > overflow(12) > syscall(8) > brk(9) > raddr_error(4) > waddr_error(5) > eret.
REQ-014 In the cycle of acceptance, exc_wen/exl_clr and the badvaddr strobes SHALL be driven combinationally, with commit_block=1.
REQ-015 For an exception or interrupt, the block SHALL output exc_wen=1, exccode per REQ-013, epc_wdata=wb_pc, and latch redirect_pc=EXC_VEC.
REQ-016 For eret alone, the block SHALL output exl_clr=1 and latch redirect_pc=epc.
REQ-017 For fetch_error, the block SHALL output badvaddr_wen=1 with badvaddr_wdata=wb_pc.
REQ-018 For raddr_error or waddr_error (and no fetch_error), the block SHALL output badvaddr_wen=1 with badvaddr_wdata=dm_addr.
REQ-019 FSM transitions SHALL be:
- IDLE -> CANCEL on accepted event.
- CANCEL -> REDIRECT unconditionally after 1 cycle.
- REDIRECT -> IDLE on redirect_ready.
REQ-020 cancel SHALL be 1 exactly in CANCEL; redirect_valid SHALL be 1 exactly in REDIRECT.
REQ-021 redirect_pc SHALL be held stable while redirect_valid=1.
REQ-022 commit_block SHALL be 1 in CANCEL and REDIRECT, and in IDLE when an event is accepted; otherwise 0.
REQ-023 While not in IDLE, all event inputs SHALL be ignored; no exc_wen, exl_clr or badvaddr_wen is issued.
REQ-024 If redirect_ready=1 on the first REDIRECT cycle, redirect_valid SHALL last exactly 1 cycle.
REQ-025 wb_valid=0 SHALL never trigger an event, even with exception bits set.
REQ-026 hw_int SHALL pass through a 2-flop synchronizer into cause_ip_hw, giving 2 cycles of latency.

Reset
REQ-027 When resetn=0 at a clk edge, the FSM SHALL return to IDLE from any state, including mid-REDIRECT.
REQ-028 On reset, all outputs SHALL be 0, including redirect_pc=0 and both synchronizer stages.

Structure
REQ-029 Package cp0_pkg SHALL hold:
- ExcCode constants: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12.
- FSM state encoding.
- EXC_VEC default.
REQ-030 Sub-module int_sync (parameterised-width 2-flop synchronizer) SHALL implement REQ-026.

Verification
REQ-031 syscall, wb_valid=1, wb_pc=0xBFC00100 in IDLE -> exc_wen=1, exccode=8, epc_wdata=0xBFC00100 that cycle; cancel next cycle; redirect_valid with redirect_pc=0xBFC00380 after that.
REQ-032 fetch_error+overflow together, wb_pc=0xBFC00203 -> exccode=4, badvaddr_wdata=0xBFC00203; no overflow code.
REQ-033 eret, epc=0xBFC00040, redirect_ready held 0 for 3 cycles -> exl_clr pulse; redirect_valid held 3+ cycles with redirect_pc=0xBFC00040; return to IDLE after ready.
REQ-034 hw_int[2]=1, status_im[4]=1, ie=1, exl=0 -> cause_ip_hw[2]=1 after 2 cycles; next valid WB -> exccode=0, commit_block=1.
REQ-035 A second syscall during CANCEL/REDIRECT -> no exc_wen; resetn=0 mid-REDIRECT -> IDLE, all outputs 0 next cycle.
